// File: rtl/tight_acc_seq.sv
// tight_acc_seq: command-driven streaming accumulator; reads count 64B lines from base
// and sums the low 64 bits of each returned line, with out-of-order responses.
module tight_acc_seq #(
    parameter int MAX_OUTST = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_val,
    output logic         busy,
    input  logic [5:0]   cmd_opcode,
    input  logic [63:0]  cmd_config_data,
    output logic         resp_val,
    input  logic         resp_rdy,
    output logic [63:0]  resp_data,
    input  logic         mem_req_rdy,
    output logic         mem_req_val,
    output logic [5:0]   mem_req_transid,
    output logic [39:0]  mem_req_addr,
    input  logic         mem_resp_val,
    input  logic [5:0]   mem_resp_transid,
    input  logic [511:0] mem_resp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
    state_t state_q, state_d;
    logic [39:0] base_q, base_d, ptr_q, ptr_d;
    logic [15:0] count_q, count_d, idx_q, idx_d;
    logic [63:0] sum_q, sum_d, resp_data_q, resp_data_d, pend_q, pend_d;
    logic [6:0]  outst_q, outst_d;
    logic        accept, fire, hit;
    assign busy            = state_q != IDLE;
    assign resp_val        = state_q == RESP;
    assign resp_data       = resp_data_q;
    assign mem_req_val     = state_q == ISSUE && outst_q < 7'(MAX_OUTST);
    assign mem_req_addr    = ptr_q;
    assign mem_req_transid = idx_q[5:0];
    assign accept          = cmd_val && !busy;
    assign fire            = mem_req_val && mem_req_rdy;
    // Responses whose transid is not pending (stray or pre-reset) are dropped here.
    assign hit             = mem_resp_val && pend_q[mem_resp_transid];
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        resp_data_d = resp_data_q;
        ptr_d       = fire ? ptr_q + 40'd64 : ptr_q;
        idx_d       = fire ? idx_q + 16'd1 : idx_q;
        sum_d       = hit ? sum_q + mem_resp_data[63:0] : sum_q;
        outst_d     = outst_q + 7'(fire) - 7'(hit);
        pend_d      = pend_q;
        if (fire)
            pend_d[mem_req_transid] = 1'b1;
        if (hit)
            pend_d[mem_resp_transid] = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = RESP;
                resp_data_d = cmd_config_data;
                case (cmd_opcode)
                    6'd0: begin
                        base_d      = {cmd_config_data[39:6], 6'b0};
                        resp_data_d = {24'b0, cmd_config_data[39:6], 6'b0};
                    end
                    6'd1: begin
                        count_d     = cmd_config_data[15:0];
                        resp_data_d = {48'b0, cmd_config_data[15:0]};
                    end
                    6'd2: begin
                        sum_d       = '0;
                        idx_d       = '0;
                        ptr_d       = base_q;
                        resp_data_d = '0;
                        state_d     = count_q == 16'd0 ? RESP : ISSUE;
                    end
                    6'd3: resp_data_d = sum_q;
                    default: ;
                endcase
            end
            ISSUE: state_d = fire && idx_q == count_q - 16'd1 ? DRAIN : ISSUE;
            DRAIN: if (outst_q == 7'd0) begin
                state_d     = RESP;
                resp_data_d = sum_q;
            end
            RESP: state_d = resp_rdy ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            resp_data_q <= '0;
            pend_q      <= '0;
            outst_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            resp_data_q <= resp_data_d;
            pend_q      <= pend_d;
            outst_q     <= outst_d;
        end
    end
endmodule

// File: tb/tb_tight_acc_seq.sv
// tb_tight_acc_seq: directed bench for tight_acc_seq; two instances (MAX_OUTST 8 and 2)
// share inputs and the selected one's outputs are observed.
module tb_tight_acc_seq;
    logic clk = 0, rst_n = 0, sel = 0;
    logic cmd_val = 0, resp_rdy = 0, mem_req_rdy = 1, mem_resp_val = 0;
    logic [5:0] cmd_opcode = 0, mem_resp_transid = 0;
    logic [63:0] cmd_config_data = 0;
    logic [511:0] mem_resp_data = 0;
    logic busy_a, resp_val_a, mem_req_val_a, busy_b, resp_val_b, mem_req_val_b;
    logic [63:0] resp_data_a, resp_data_b;
    logic [5:0] tid_a, tid_b;
    logic [39:0] addr_a, addr_b;
    logic busy, resp_val, mem_req_val;
    logic [63:0] resp_data;
    logic [5:0] mem_req_transid;
    logic [39:0] mem_req_addr;
    int checks = 0, errors = 0, cyc = 0, last_lat = 0;
    int bench_out = 0, peak = 0, viol = 0, stab_err = 0, stall_seen = 0;
    logic [63:0] bench_pend = 0;
    logic prev_stall = 0, fire, good;
    logic [39:0] p_addr;
    logic [5:0] p_tid;
    logic [39:0] addr_q[$];
    logic [5:0] tid_q[$];
    int fire_cyc[$];
    logic [63:0] rdat[8];
    logic [63:0] r;

    always #5 clk = ~clk;

    tight_acc_seq dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .busy(busy_a), .cmd_opcode(cmd_opcode),
        .cmd_config_data(cmd_config_data), .resp_val(resp_val_a), .resp_rdy(resp_rdy),
        .resp_data(resp_data_a), .mem_req_rdy(mem_req_rdy), .mem_req_val(mem_req_val_a),
        .mem_req_transid(tid_a), .mem_req_addr(addr_a), .mem_resp_val(mem_resp_val),
        .mem_resp_transid(mem_resp_transid), .mem_resp_data(mem_resp_data)
    );
    tight_acc_seq #(.MAX_OUTST(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_val(cmd_val), .busy(busy_b), .cmd_opcode(cmd_opcode),
        .cmd_config_data(cmd_config_data), .resp_val(resp_val_b), .resp_rdy(resp_rdy),
        .resp_data(resp_data_b), .mem_req_rdy(mem_req_rdy), .mem_req_val(mem_req_val_b),
        .mem_req_transid(tid_b), .mem_req_addr(addr_b), .mem_resp_val(mem_resp_val),
        .mem_resp_transid(mem_resp_transid), .mem_resp_data(mem_resp_data)
    );
    assign busy            = sel ? busy_b : busy_a;
    assign resp_val        = sel ? resp_val_b : resp_val_a;
    assign resp_data       = sel ? resp_data_b : resp_data_a;
    assign mem_req_val     = sel ? mem_req_val_b : mem_req_val_a;
    assign mem_req_transid = sel ? tid_b : tid_a;
    assign mem_req_addr    = sel ? addr_b : addr_a;

    // Observer one time unit before each rising edge: logs fires, tracks its own
    // pending set and outstanding count, and checks request stability under stall.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            bench_out = 0;
            bench_pend = '0;
            prev_stall = 0;
        end else begin
            fire = mem_req_val && mem_req_rdy;
            good = mem_resp_val && bench_pend[mem_resp_transid];
            if (prev_stall && (!mem_req_val || mem_req_addr != p_addr || mem_req_transid != p_tid))
                stab_err++;
            prev_stall = mem_req_val && !mem_req_rdy;
            if (prev_stall) stall_seen++;
            p_addr = mem_req_addr;
            p_tid = mem_req_transid;
            if (mem_req_val && bench_out >= (sel ? 2 : 8)) viol++;
            if (good) bench_pend[mem_resp_transid] = 1'b0;
            if (fire) begin
                bench_pend[mem_req_transid] = 1'b1;
                addr_q.push_back(mem_req_addr);
                tid_q.push_back(mem_req_transid);
                fire_cyc.push_back(cyc);
            end
            bench_out = bench_out + int'(fire) - int'(good);
            if (bench_out > peak) peak = bench_out;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        addr_q.delete();
        tid_q.delete();
        fire_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
    endtask

    task automatic do_cmd(input logic [5:0] op, input logic [63:0] d, output logic [63:0] res);
        int t;
        @(negedge clk);
        t = 0;
        while (busy && t < 100) begin @(negedge clk); t++; end
        cmd_val = 1; cmd_opcode = op; cmd_config_data = d;
        @(negedge clk);
        cmd_val = 0;
        t = 0;
        while (!resp_val && t < 500) begin @(negedge clk); t++; end
        last_lat = t;
        if (!resp_val) check("resp_timeout", 64'(resp_val), 64'd1);
        res = resp_data;
        resp_rdy = 1;
        @(negedge clk);
        resp_rdy = 0;
    endtask

    task automatic send(input logic [5:0] tid, input logic [63:0] d);
        mem_resp_val = 1; mem_resp_transid = tid;
        mem_resp_data = {{7{64'hA5A5_5A5A_A5A5_5A5A}}, d};
        @(negedge clk);
        mem_resp_val = 0;
    endtask

    // Returns the n logged requests in order, each dly cycles after it fired.
    task automatic resp_seq(input int n, input int dly);
        int t;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (addr_q.size() <= k && t < 400) begin @(negedge clk); t++; end
            if (addr_q.size() <= k) begin check("req_timeout", 64'(addr_q.size()), 64'(k + 1)); return; end
            while (cyc < fire_cyc[k] + dly) @(negedge clk);
            send(tid_q[k], rdat[k]);
        end
    endtask

    task automatic ooo_resp();
        int t = 0;
        while (addr_q.size() < 4 && t < 200) begin @(negedge clk); t++; end
        check("ooo_issued", 64'(addr_q.size()), 64'd4);
        send(6'd3, 64'd10);
        send(6'd9, 64'h1000);
        send(6'd0, 64'd20);
        send(6'd2, 64'd30);
        repeat (3) @(negedge clk);
        check("ooo_not_early", 64'(resp_val), 64'd0);
        check("ooo_busy", 64'(busy), 64'd1);
        send(6'd1, 64'd40);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_val", 64'(resp_val), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_req_val", 64'(mem_req_val), 64'd0);
        check("rst_addr", 64'(mem_req_addr), 64'd0);
        check("rst_tid", 64'(mem_req_transid), 64'd0);
        rst_n = 1;
        do_cmd(6'h3F, 64'hDEAD_BEEF_CAFE_F00D, r);
        check("echo", r, 64'hDEAD_BEEF_CAFE_F00D);
        check("echo_lat", 64'(last_lat), 64'd0);
        do_cmd(6'd0, 64'h1000_0000_1037, r);
        check("set_base", r, 64'h1000);
        check("set_base_lat", 64'(last_lat), 64'd0);
        do_cmd(6'd1, 64'hABCD_0004, r);
        check("set_count", r, 64'd4);
        do_cmd(6'd3, 64'd0, r);
        check("read_sum_init", r, 64'd0);
        // In-order stream with a stalling request channel.
        clear_log();
        stall_seen = 0; stab_err = 0;
        rdat[0] = 1; rdat[1] = 2; rdat[2] = 3; rdat[3] = 4;
        fork
            do_cmd(6'd2, 64'd0, r);
            resp_seq(4, 2);
            begin
                for (int i = 0; i < 30; i++) begin @(negedge clk); mem_req_rdy = (i % 3 != 1); end
                mem_req_rdy = 1;
            end
        join
        check("start_sum", r, 64'd10);
        check("start_nreq", 64'(addr_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < addr_q.size(); k++) begin
            check($sformatf("addr%0d", k), 64'(addr_q[k]), 64'h1000 + 64'(64 * k));
            check($sformatf("tid%0d", k), 64'(tid_q[k]), 64'(k));
        end
        check("stall_seen", 64'(stall_seen > 0), 64'd1);
        check("stall_stable", 64'(stab_err), 64'd0);
        // Out-of-order responses with a stray transid.
        do_cmd(6'd0, 64'h4000, r);
        clear_log();
        fork
            do_cmd(6'd2, 64'd0, r);
            ooo_resp();
        join
        check("ooo_sum", r, 64'd100);
        do_cmd(6'd3, 64'd0, r);
        check("read_sum", r, 64'd100);
        // START with count 0, response back-pressured.
        do_cmd(6'd1, 64'd0, r);
        clear_log();
        @(negedge clk);
        cmd_val = 1; cmd_opcode = 6'd2;
        @(negedge clk);
        cmd_val = 0;
        check("z_resp_val", 64'(resp_val), 64'd1);
        check("z_resp_data", resp_data, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("z_hold_data%0d", i), resp_data, 64'd0);
            check($sformatf("z_hold_busy%0d", i), 64'(busy && resp_val), 64'd1);
        end
        resp_rdy = 1;
        @(negedge clk);
        resp_rdy = 0;
        check("z_busy_after", 64'(busy), 64'd0);
        check("z_no_req", 64'(addr_q.size()), 64'd0);
        // Address wrap at the top of the 40-bit space.
        do_cmd(6'd0, 64'hFF_FFFF_FFC0, r);
        do_cmd(6'd1, 64'd2, r);
        clear_log();
        rdat[0] = 5; rdat[1] = 6;
        fork
            do_cmd(6'd2, 64'd0, r);
            resp_seq(2, 1);
        join
        check("wrap_sum", r, 64'd11);
        check("wrap_addr0", 64'(addr_q.size() > 0 ? addr_q[0] : 40'h1), 64'hFF_FFFF_FFC0);
        check("wrap_addr1", 64'(addr_q.size() > 1 ? addr_q[1] : 40'h1), 64'd0);
        // MAX_OUTST=2 with slow memory; sum wraps mod 2^64.
        sel = 1;
        do_reset();
        do_cmd(6'd0, 64'h2000, r);
        do_cmd(6'd1, 64'd5, r);
        clear_log();
        peak = 0; viol = 0;
        rdat[0] = 64'h1111; rdat[1] = 64'hFFFF_FFFF_FFFF_FFFF; rdat[2] = 3; rdat[3] = 64'h100; rdat[4] = 7;
        fork
            do_cmd(6'd2, 64'd0, r);
            resp_seq(5, 10);
        join
        check("lim_sum", r, 64'h121A);
        check("lim_viol", 64'(viol), 64'd0);
        check("lim_peak", 64'(peak), 64'd2);
        check("lim_addr4", 64'(addr_q.size() > 4 ? addr_q[4] : 40'h0), 64'h2100);
        // Reset in the middle of ISSUE with three requests outstanding.
        sel = 0;
        do_reset();
        do_cmd(6'd0, 64'h8000, r);
        do_cmd(6'd1, 64'd10, r);
        clear_log();
        @(negedge clk);
        cmd_val = 1; cmd_opcode = 6'd2;
        @(negedge clk);
        cmd_val = 0;
        for (int t = 0; t < 50 && addr_q.size() < 3; t++) @(negedge clk);
        mem_req_rdy = 0;
        check("mid_nreq", 64'(addr_q.size()), 64'd3);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_req_val", 64'(mem_req_val), 64'd1);
        #2 rst_n = 0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_req_val", 64'(mem_req_val), 64'd0);
        check("arst_addr", 64'(mem_req_addr), 64'd0);
        check("arst_tid", 64'(mem_req_transid), 64'd0);
        check("arst_resp", {63'd0, resp_val} | resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1;
        mem_req_rdy = 1;
        send(6'd0, 64'd99);
        send(6'd1, 64'd99);
        send(6'd2, 64'd99);
        check("late_req_val", 64'(mem_req_val), 64'd0);
        check("late_busy", 64'(busy), 64'd0);
        do_cmd(6'd3, 64'd0, r);
        check("late_sum", r, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
